// File: rtl/bali_lib_pkg.sv
// Shared types and block/TLP geometry for the tx DMA block scheduler.
// 4KB blocks are cut into 128B memory-write TLPs of 256-bit beats.
package bali_lib_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHK   = 3'd1,
    STALL = 3'd2,
    HDR   = 3'd3,
    DATA  = 3'd4,
    DRAIN = 3'd5,
    DONE  = 3'd6
  } sched_state_e;

  localparam int BLK_BEATS = 128;
  localparam int TLP_BEATS = 4;
  localparam int TLP_BYTES = 128;
  localparam int BLK_BYTES = 4096;

endpackage

// File: rtl/tx_dma_ring_ptr.sv
// Per-link host ring producer pointers; one-cycle increment, full flag registered one cycle
// behind the pointers. No backpressure: the scheduler only strobes inc at block completion.
module tx_dma_ring_ptr #(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS),
  parameter int RING_AW    = 8
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic                          inc,
  input  logic [PORT_WIDTH-1:0]         inc_link,
  input  logic [PORTS-1:0][RING_AW-1:0] rd_ptr,
  output logic [PORTS-1:0][RING_AW-1:0] wr_ptr,
  output logic [PORTS-1:0]              ring_full
);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr    <= '0;
      ring_full <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (inc && (inc_link == PORT_WIDTH'(i)))
          wr_ptr[i] <= wr_ptr[i] + RING_AW'(1);
        // one slot is always left empty so full and empty stay distinguishable
        ring_full[i] <= ((wr_ptr[i] + RING_AW'(1)) == rd_ptr[i]);
      end
    end
  end

endmodule

// File: rtl/tx_dma_blk_scheduler.sv
// Drains whole 4KB blocks from the arbiter FIFO into 128B host-ring TLPs; data is a combinational
// pass-through, headers wait on iTLP_GNT, beats wait on iTLP_READY, and a full ring stalls the block.
module tx_dma_blk_scheduler #(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS),
  parameter int RING_AW    = 8,
  parameter int TLP_BEATS  = bali_lib_pkg::TLP_BEATS,
  parameter int BLK_BEATS  = bali_lib_pkg::BLK_BEATS
) (
  input  logic                          iCLK,
  input  logic                          iRST_N,
  input  logic [255:0]                  iFIFO_DATA,
  input  logic                          iFIFO_EMPTY,
  input  logic [7:0]                    iFIFO_USED,
  input  logic [PORT_WIDTH-1:0]         iLINK_NUMBER,
  output logic                          oFIFO_RD_ACK,
  output logic                          oBLK_DONE_PULSE,
  output logic                          oHIP_BLK_DONE,
  output logic [PORT_WIDTH-1:0]         oHIP_LINK_NUMBER,
  output logic                          oTLP_REQ,
  input  logic                          iTLP_GNT,
  output logic [63:0]                   oTLP_ADDR,
  output logic [9:0]                    oTLP_LEN_DW,
  output logic [255:0]                  oTLP_DATA,
  output logic                          oTLP_DATA_V,
  output logic                          oTLP_EOP,
  input  logic                          iTLP_READY,
  input  logic [PORTS-1:0]              iREG_LINK_EN,
  input  logic [PORTS-1:0][63:0]        iREG_RING_BASE,
  input  logic [PORTS-1:0][RING_AW-1:0] iREG_RD_PTR,
  output logic [PORTS-1:0][RING_AW-1:0] oREG_WR_PTR,
  output logic [PORTS-1:0]              oREG_RING_FULL,
  output logic [2:0]                    oREG_SM_PS
);
  import bali_lib_pkg::*;

  localparam int BEAT_W = $clog2(BLK_BEATS);
  localparam int SUB_W  = $clog2(TLP_BEATS);
  localparam int IDX_W  = $clog2(BLK_BEATS / TLP_BEATS);
  localparam int BLK_SH = $clog2(BLK_BYTES);
  localparam int TLP_SH = $clog2(TLP_BYTES);

  sched_state_e              state_q, state_d;
  logic [PORT_WIDTH-1:0]     lnk_q;
  logic [IDX_W-1:0]          tlp_idx_q;
  logic [BEAT_W-1:0]         beat_cnt_q;
  logic                      tx_blk_q;
  logic                      gap_q;

  logic                      fifo_rd_ack;
  logic                      tlp_req;
  logic                      data_v;
  logic                      blk_done;
  logic                      ring_inc;
  logic                      tlp_last;
  logic                      ring_full_now;
  logic [63:0]               tlp_addr;
  logic [PORTS-1:0][RING_AW-1:0] wr_ptr;

  tx_dma_ring_ptr #(
    .PORTS      (PORTS),
    .PORT_WIDTH (PORT_WIDTH),
    .RING_AW    (RING_AW)
  ) u_ring_ptr (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .inc       (ring_inc),
    .inc_link  (lnk_q),
    .rd_ptr    (iREG_RD_PTR),
    .wr_ptr    (wr_ptr),
    .ring_full (oREG_RING_FULL)
  );

  // Sampled live so a consumer-pointer move is seen the same cycle it lands.
  assign ring_full_now = ((wr_ptr[lnk_q] + RING_AW'(1)) == iREG_RD_PTR[lnk_q]);
  assign tlp_addr = iREG_RING_BASE[lnk_q]
                  + (64'(wr_ptr[lnk_q]) << BLK_SH)
                  + (64'(tlp_idx_q) << TLP_SH);

  always_comb begin
    state_d     = state_q;
    fifo_rd_ack = 1'b0;
    tlp_req     = 1'b0;
    data_v      = 1'b0;
    blk_done    = 1'b0;
    ring_inc    = 1'b0;
    tlp_last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!gap_q && !iFIFO_EMPTY && (iFIFO_USED >= 8'(BLK_BEATS)))
          state_d = CHK;
      end
      CHK, STALL: begin
        if (!iREG_LINK_EN[lnk_q])
          state_d = DRAIN;
        else if (ring_full_now)
          state_d = STALL;
        else
          state_d = HDR;
      end
      HDR: begin
        tlp_req = 1'b1;
        if (iTLP_GNT)
          state_d = DATA;
      end
      DATA: begin
        data_v = 1'b1;
        if (iTLP_READY) begin
          fifo_rd_ack = 1'b1;
          if (beat_cnt_q[SUB_W-1:0] == '1) begin
            tlp_last = 1'b1;
            state_d  = (tlp_idx_q == '1) ? DONE : HDR;
          end
        end
      end
      DRAIN: begin
        fifo_rd_ack = 1'b1;
        if (beat_cnt_q == '1)
          state_d = DONE;
      end
      DONE: begin
        blk_done = 1'b1;
        ring_inc = tx_blk_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      lnk_q      <= '0;
      tlp_idx_q  <= '0;
      beat_cnt_q <= '0;
      tx_blk_q   <= 1'b0;
      gap_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d == CHK))
        lnk_q <= iLINK_NUMBER;
      if ((state_q == CHK) || (state_q == STALL))
        tx_blk_q <= (state_d == HDR);
      if (fifo_rd_ack)
        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      if (tlp_last)
        tlp_idx_q <= tlp_idx_q + IDX_W'(1);
      // second idle cycle lets the upstream used-count settle after the pop
      gap_q <= (state_q == DONE);
    end
  end

  assign oFIFO_RD_ACK     = fifo_rd_ack;
  assign oBLK_DONE_PULSE  = blk_done;
  assign oHIP_BLK_DONE    = blk_done;
  assign oHIP_LINK_NUMBER = blk_done ? lnk_q : '0;
  assign oTLP_REQ         = tlp_req;
  assign oTLP_ADDR        = tlp_req ? tlp_addr : '0;
  assign oTLP_LEN_DW      = 10'(TLP_BYTES / 4);
  assign oTLP_DATA        = data_v ? iFIFO_DATA : '0;
  assign oTLP_DATA_V      = data_v;
  assign oTLP_EOP         = data_v && (beat_cnt_q[SUB_W-1:0] == '1);
  assign oREG_WR_PTR      = wr_ptr;
  assign oREG_SM_PS       = state_q;

endmodule
